// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: counts rising edges of tick_in as a packed NDIGITS-digit BCD
// value, with run/pause toggling (start_stop) and a clear-to-idle control.
//
// Control protocol: there is no valid/ready handshake on this block. Every
// input is sampled at each rising clk edge. start_stop and clear are plain
// level requests: each cycle they are high counts as one request. tick_in is
// edge-detected internally, so its pulse width does not matter. Outputs are
// valid every cycle after reset.
module bcd_stopwatch #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_in,
  input  logic                   start_stop,
  input  logic                   clear,
  output logic [4*NDIGITS-1:0]   digits,
  output logic                   running,
  output logic                   wrap,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_tick_d;
  logic [4*NDIGITS-1:0]  r_digits;
  logic                  r_running;
  logic                  r_wrap;

  logic                  w_edge;
  logic                  w_count;
  logic [4*NDIGITS-1:0]  w_inc_digits;
  logic                  w_all_nines;

  // Rising edge of tick_in relative to the previous cycle's sample.
  assign w_edge  = tick_in & ~r_tick_d;
  // A count event only takes effect while running.
  assign w_count = w_edge & (r_state == S_RUN);

  // Register the previous tick_in level; updates in every state.
  always_ff @(posedge clk) begin
    if (rst) r_tick_d <= 1'b0;
    else     r_tick_d <= tick_in;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: clear beats start_stop; start_stop toggles run/pause.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else if (start_stop) begin
      case (r_state)
        S_IDLE:  w_next_state = S_RUN;
        S_RUN:   w_next_state = S_PAUSE;
        S_PAUSE: w_next_state = S_RUN;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // BCD increment: a digit steps when every lower digit is 9; a 9 steps to 0.
  always_comb begin
    logic v_carry;
    w_inc_digits = r_digits;
    v_carry      = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v_carry) begin
        w_inc_digits[4*i +: 4] = (r_digits[4*i +: 4] == 4'd9) ? 4'd0
                                                               : r_digits[4*i +: 4] + 4'd1;
      end
      v_carry = v_carry & (r_digits[4*i +: 4] == 4'd9);
    end
    w_all_nines = v_carry;
  end

  // Digit registers: clear zeroes, otherwise step on a counted edge.
  always_ff @(posedge clk) begin
    if (rst || clear)  r_digits <= '0;
    else if (w_count)  r_digits <= w_inc_digits;
  end

  // Rollover pulse, aligned with the cycle digits first reads all zeros.
  always_ff @(posedge clk) begin
    if (rst) r_wrap <= 1'b0;
    else     r_wrap <= w_count & w_all_nines & ~clear;
  end

  // Running flag tracks the state register exactly (decoded from next state).
  always_ff @(posedge clk) begin
    if (rst) r_running <= 1'b0;
    else     r_running <= (w_next_state == S_RUN);
  end

  assign digits    = r_digits;
  assign running   = r_running;
  assign wrap      = r_wrap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: a 4-digit and a 2-digit instance share stimulus.
// The driver updates an integer-count reference model and queues the expected
// outputs; a monitor pops and compares after every rising clock edge.
module tb_bcd_stopwatch;

  localparam int W = 27;  // {digits4[15:0], running, wrap4, digits2[7:0], wrap2}

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst        = 1'b1;
  logic tick_in    = 1'b0;
  logic start_stop = 1'b0;
  logic clear      = 1'b0;

  logic [15:0] digits4;
  logic        running4, wrap4;
  logic [1:0]  dbg4;
  logic [7:0]  digits2;
  logic        running2, wrap2;
  logic [1:0]  dbg2;

  bcd_stopwatch #(.NDIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .digits(digits4), .running(running4), .wrap(wrap4),
    .dbg_state(dbg4)
  );

  bcd_stopwatch #(.NDIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .digits(digits2), .running(running2), .wrap(wrap2),
    .dbg_state(dbg2)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int  checks  = 0;
  int  errors  = 0;
  int  cyc     = 0;
  bit  started = 1'b0;
  bit  done    = 1'b0;

  // Reference model: plain integer counts and a run/pause/idle mode.
  int m_cnt4 = 0;
  int m_cnt2 = 0;
  int m_mode = 0;          // 0 idle, 1 run, 2 pause
  bit m_prev = 1'b0;
  bit m_wrap4 = 1'b0;
  bit m_wrap2 = 1'b0;

  function automatic logic [31:0] to_bcd(input int v, input int n);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Driver: apply one cycle of inputs and queue the outputs expected after it.
  task automatic step(input bit t, input bit ss, input bit clr, input bit rs);
    logic [31:0] b4, b2;
    bit e;
    @(negedge clk);
    tick_in    = t;
    start_stop = ss;
    clear      = clr;
    rst        = rs;
    m_wrap4 = 1'b0;
    m_wrap2 = 1'b0;
    if (rs) begin
      m_cnt4 = 0; m_cnt2 = 0; m_mode = 0; m_prev = 1'b0;
    end else begin
      e = t && !m_prev;
      m_prev = t;
      if (clr) begin
        m_cnt4 = 0; m_cnt2 = 0; m_mode = 0;
      end else begin
        if (m_mode == 1 && e) begin
          m_cnt4 = (m_cnt4 + 1) % 10000;
          m_cnt2 = (m_cnt2 + 1) % 100;
          m_wrap4 = (m_cnt4 == 0);
          m_wrap2 = (m_cnt2 == 0);
        end
        if (ss) m_mode = (m_mode == 1) ? 2 : 1;
      end
    end
    b4 = to_bcd(m_cnt4, 4);
    b2 = to_bcd(m_cnt2, 2);
    exp_q.push_back({b4[15:0], (m_mode == 1), m_wrap4, b2[7:0], m_wrap2});
    started = 1'b1;
  endtask

  task automatic edges(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every output after each rising edge.
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("digits4",  digits4,          e[26:11]);
      chk("running4", {15'd0, running4}, {15'd0, e[10]});
      chk("wrap4",    {15'd0, wrap4},    {15'd0, e[9]});
      chk("digits2",  {8'd0, digits2},   {8'd0, e[8:1]});
      chk("running2", {15'd0, running2}, {15'd0, e[10]});
      chk("wrap2",    {15'd0, wrap2},    {15'd0, e[0]});
    end else if (started && !done) begin
      checks++;
      errors++;
      $display("FAIL queue cycle %0d: got empty expected entry", cyc);
    end
  end

  // Stimulus
  initial begin
    // Reset with tick toggling, then released with tick high and no start.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1 & 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Basic count to 12, then a 5-cycle-wide tick adds one.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(12);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);   // single-cycle tick
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Edge with start_stop in RUN (counts, pauses) and in PAUSE (no count).
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Multi-digit carry to 0x1000, then on to a full 4-digit rollover.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(999);
    edges(1);
    edges(8999);
    edges(2);

    // Rollover edge coinciding with clear on the 2-digit instance.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(99);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Pause/resume.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(2);

    // Collisions: clear+edge at 41, then start_stop+edge in IDLE.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(41);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);   // start_stop+clear: clear wins
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-count with tick high.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    edges(3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4000; k++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 299) == 0));
    end

    @(posedge clk);
    #2;
    done = 1'b1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Downstream consumer of the free-running `counter` tick. It detects rising edges on that 1-bit `out`, wired here as `tick_in`, and accumulates them as a packed multi-digit BCD count. Counting is under start/stop/clear control. The BCD digits feed the seven-segment display driver, and `running` drives a status LED.

## Interface
- `NDIGITS`, default 4: number of BCD digits; legal range 1..8.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `tick_in`  in  1: `counter` output; each 0→1 transition is one count event. The level or pulse width is irrelevant.
- `start_stop`  in  1: single-cycle pulse that toggles run/pause.
- `clear`  in  1: single-cycle pulse that zeroes the count and stops.
- `digits`  out  4*NDIGITS: packed BCD.
  - Digit 0, the least significant, is at [3:0].
  - Every nibble is always in the range 0..9.
- `running`  out  1: high while the FSM is in RUN.
- `wrap`  out  1: one-cycle pulse when the count rolls over from all-9s to zero.

## Operation
- Edge detect:
  - `tick_d` is a registered copy of `tick_in` and updates every cycle in every state.
  - `edge = tick_in & ~tick_d`, evaluated combinationally.
- FSM states are IDLE, RUN and PAUSE.
  - IDLE: count is 0, stopped. `start_stop` → RUN.
  - RUN: each `edge` increments the count. `start_stop` → PAUSE.
  - PAUSE: count held, edges ignored. `start_stop` → RUN, resuming from the held value.
  - `clear` in any state → IDLE, with `digits` = 0.
- Priority, highest first: `rst`, `clear`, then `start_stop` and counting.
- Increment rules:
  - Digit i increments when `edge` is high, the state is RUN, and all lower digits are 9.
  - A digit at 9 that increments becomes 0.
  - The all-9s value plus one becomes all-0s, asserts `wrap`, and counting continues in RUN.
- Outputs:
  - `running` is a registered decode of the state, equal to 1 exactly when the state is RUN.
  - `wrap` is registered.
  - `digits` comes directly from the digit registers.
- Reset values:
  - State IDLE.
  - `digits` = 0.
  - `running` = 0.
  - `wrap` = 0.
  - `tick_d` = 0.

## Timing
- Count latency: `digits` shows the new value in the cycle after the rising clock edge at which `tick_in`=1 and `tick_d`=0 are sampled in RUN.
- A `tick_in` held high for N cycles produces exactly one increment.
- A `tick_in` high for only one cycle also produces one increment.
- `wrap` is high for exactly the one cycle in which `digits` first reads all-0s after a rollover.
- `running` rises in the cycle after the `start_stop` sample that causes IDLE→RUN or PAUSE→RUN. It falls likewise on RUN→PAUSE or on `clear`.
- Simultaneous events:
  - `edge` + `start_stop` in IDLE: not counted, because the state at that edge is IDLE. The next state is RUN.
  - `edge` + `start_stop` in RUN: the count increments and the next state is PAUSE.
  - `edge` + `start_stop` in PAUSE: not counted. The next state is RUN.
  - `edge` + `clear`: `clear` wins. `digits` = 0, `wrap` = 0, state IDLE.
  - `start_stop` + `clear`: `clear` wins.
  - Rollover edge + `clear`: no `wrap` pulse.
- Reset asserted mid-count: the next cycle shows all reset values, regardless of state or `tick_in`.
- `tick_in` high while leaving reset: `tick_d` becomes 1 one cycle after reset is released, with no count because the state is IDLE.
- Neither `start_stop` nor `clear` is edge-detected. A pulse held high for k cycles acts as k requests. Upstream provides single-cycle pulses.

## Test plan
- Reset: hold `rst` for 2 cycles with `tick_in` toggling. Expect `digits`=0x0000, `running`=0 and `wrap`=0 throughout, and these values persist after release with no `start_stop`.
- Basic count and carry: pulse `start_stop`, then apply 12 `tick_in` rising edges. Expect `digits`=0x0012 and `running`=1. Check one cycle of latency per edge, and that holding `tick_in` high for 5 cycles adds only 1.
- Multi-digit carry: apply edges from 0x0999. Expect 0x1000 on the next edge, with no `wrap`.
- Wrap, with `NDIGITS`=2: from 0x99, apply 1 edge. Expect `digits`=0x00 with `wrap`=1 in that same cycle only; the next edge gives 0x01.
- Pause/resume: at 0x0005, pulse `start_stop` and apply 4 edges. Expect 0x0005 held and `running`=0. Pulse `start_stop` again and apply 2 edges; expect 0x0007.
- Collisions: in RUN at 0x0041, apply `clear` and `edge` in the same cycle. Expect 0x0000 in IDLE. Then apply `start_stop` and `edge` together in IDLE; expect the count to stay 0 with `running`=1.
